// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode, select and state types for the ALU issue controller.
// Purely declarative; no latency or backpressure of its own.
package alu_pkg;

    localparam int MUL_LAT_DEFAULT = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_MULH = 4'd9,
        OP_SLT  = 4'd10,
        OP_SLTU = 4'd11,
        OP_MAC  = 4'd12
    } alu_op_e;

    // Field order matches the result selector's select ports.
    typedef struct packed {
        logic addsub;
        logic shift;
        logic logic_op;
        logic mul_hi;
        logic mul_low;
        logic com;
        logic mac;
    } alu_sel_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Opcode-in / result-out handshake bundle between issue and the ALU selector.
// Master drives opcodes and writeback ready; slave is the issue controller.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic    op_valid_i;
    alu_op_e op_code_i;
    logic    op_ready_o;
    logic    addsub_sel_o;
    logic    shift_sel_o;
    logic    logic_sel_o;
    logic    mul_sel_hi_o;
    logic    mul_sel_low_o;
    logic    com_sel_o;
    logic    mac_sel_o;
    logic    sub_o;
    logic    mul_start_o;
    logic    mac_commit_o;
    logic    result_valid_o;
    logic    result_ready_i;
    logic    illegal_o;

    modport master (
        output op_valid_i, op_code_i, result_ready_i,
        input  op_ready_o, addsub_sel_o, shift_sel_o, logic_sel_o, mul_sel_hi_o,
               mul_sel_low_o, com_sel_o, mac_sel_o, sub_o, mul_start_o,
               mac_commit_o, result_valid_o, illegal_o
    );

    modport slave (
        input  op_valid_i, op_code_i, result_ready_i,
        output op_ready_o, addsub_sel_o, shift_sel_o, logic_sel_o, mul_sel_hi_o,
               mul_sel_low_o, com_sel_o, mac_sel_o, sub_o, mul_start_o,
               mac_commit_o, result_valid_o, illegal_o
    );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode decode into one-hot selects, subtract, class and illegal flags.
// Zero latency; no handshake of its own.
module alu_op_decode
    import alu_pkg::*;
(
    input  alu_op_e  i_op_code,
    output alu_sel_t o_sel,
    output logic     o_sub,
    output logic     o_multi_cycle,
    output logic     o_illegal
);

    always_comb begin
        o_sel         = '0;
        o_sub         = 1'b0;
        o_multi_cycle = 1'b0;
        o_illegal     = 1'b0;
        case (i_op_code)
            OP_ADD:                 o_sel.addsub   = 1'b1;
            OP_SUB: begin
                o_sel.addsub = 1'b1;
                o_sub        = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: o_sel.shift    = 1'b1;
            OP_AND, OP_OR, OP_XOR:  o_sel.logic_op = 1'b1;
            OP_MUL: begin
                o_sel.mul_low = 1'b1;
                o_multi_cycle = 1'b1;
            end
            OP_MULH: begin
                o_sel.mul_hi  = 1'b1;
                o_multi_cycle = 1'b1;
            end
            // Compares reuse the adder in subtract mode.
            OP_SLT, OP_SLTU: begin
                o_sel.com = 1'b1;
                o_sub     = 1'b1;
            end
            OP_MAC: begin
                o_sel.mac     = 1'b1;
                o_multi_cycle = 1'b1;
            end
            default:                o_illegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU opcode at a time, sequences the MUL_LAT-cycle multiply pipe, holds the result for writeback.
// Result valid 1 cycle after a single-cycle accept, MUL_LAT after a multi-cycle one; HOLD stalls on result_ready_i low.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_issue_ctrl_if.slave   bus
);

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    issue_state_e r_state;
    issue_state_e w_state_nxt;
    logic [3:0]   r_cnt;
    alu_sel_t     r_sel;
    logic         r_sub;
    logic         r_illegal;

    alu_sel_t     w_dec_sel;
    logic         w_dec_sub;
    logic         w_dec_multi;
    logic         w_dec_illegal;
    logic         w_op_ready;
    logic         w_accept;
    logic         w_res_hs;

    alu_op_decode u_decode (
        .i_op_code     (bus.op_code_i),
        .o_sel         (w_dec_sel),
        .o_sub         (w_dec_sub),
        .o_multi_cycle (w_dec_multi),
        .o_illegal     (w_dec_illegal)
    );

    // HOLD forwards writeback ready straight to op ready so a new op can overlap the handshake.
    assign w_op_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.result_ready_i);
    assign w_accept   = bus.op_valid_i && w_op_ready;
    assign w_res_hs   = (r_state == S_HOLD) && bus.result_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_accept) begin
                    if (w_dec_illegal)    w_state_nxt = S_IDLE;
                    else if (w_dec_multi) w_state_nxt = S_BUSY;
                    else                  w_state_nxt = S_HOLD;
                end else if (w_res_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd1) w_state_nxt = S_HOLD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_sel     <= '0;
            r_sub     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_illegal <= w_accept && w_dec_illegal;
            if (w_accept) begin
                r_sel <= w_dec_sel;
                r_sub <= w_dec_sub;
                r_cnt <= w_dec_multi ? CNT_LOAD : 4'd0;
            end else if (w_res_hs) begin
                r_sel <= '0;
                r_sub <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign bus.op_ready_o     = w_op_ready;
    assign bus.addsub_sel_o   = r_sel.addsub;
    assign bus.shift_sel_o    = r_sel.shift;
    assign bus.logic_sel_o    = r_sel.logic_op;
    assign bus.mul_sel_hi_o   = r_sel.mul_hi;
    assign bus.mul_sel_low_o  = r_sel.mul_low;
    assign bus.com_sel_o      = r_sel.com;
    assign bus.mac_sel_o      = r_sel.mac;
    assign bus.sub_o          = r_sub;
    assign bus.mul_start_o    = w_accept && w_dec_multi;
    assign bus.mac_commit_o   = w_res_hs && r_sel.mac;
    assign bus.result_valid_o = (r_state == S_HOLD);
    assign bus.illegal_o      = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl with MUL_LAT=3.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam logic [6:0] SEL_NONE  = 7'b0000000;
    localparam logic [6:0] SEL_ADDSB = 7'b1000000;
    localparam logic [6:0] SEL_SHIFT = 7'b0100000;
    localparam logic [6:0] SEL_LOGIC = 7'b0010000;
    localparam logic [6:0] SEL_MULHI = 7'b0001000;
    localparam logic [6:0] SEL_MULLO = 7'b0000100;
    localparam logic [6:0] SEL_COM   = 7'b0000010;
    localparam logic [6:0] SEL_MAC   = 7'b0000001;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.MUL_LAT(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // {op_ready, result_valid, 7 selects, sub, mul_start, mac_commit, illegal}
    logic [12:0] obs;
    assign obs = {bus.op_ready_o, bus.result_valid_o,
                  bus.addsub_sel_o, bus.shift_sel_o, bus.logic_sel_o, bus.mul_sel_hi_o,
                  bus.mul_sel_low_o, bus.com_sel_o, bus.mac_sel_o,
                  bus.sub_o, bus.mul_start_o, bus.mac_commit_o, bus.illegal_o};

    function automatic logic [12:0] ex(input logic rdy, input logic vld, input logic [6:0] sel,
                                       input logic sub, input logic st, input logic cm,
                                       input logic il);
        return {rdy, vld, sel, sub, st, cm, il};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        bus.op_valid_i     = 1'b0;
        bus.op_code_i      = OP_ADD;
        bus.result_ready_i = 1'b1;
        rst_i              = 1'b1;
        #2;
        e = ex(1, 0, SEL_NONE, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_state obs=%b exp=%b", obs, e); end
        tick();
        rst_i = 1'b0;
        bus.op_valid_i = 1'b1;
        bus.op_code_i  = OP_MUL;
        #1;
        e = ex(1, 0, SEL_NONE, 0, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mul_accept obs=%b exp=%b", obs, e); end
        tick();
        bus.op_valid_i = 1'b0;
        #1;
        e = ex(0, 0, SEL_MULLO, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mul_busy obs=%b exp=%b", obs, e); end
        #2;
        rst_i = 1'b1;
        #1;
        e = ex(1, 0, SEL_NONE, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_async_clear obs=%b exp=%b", obs, e); end
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_no_result_c%0d obs=%b exp=%b", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        alu_op_e     codes [6] = '{OP_ADD, OP_SUB, OP_XOR, OP_SLTU, OP_ADD, OP_ADD};
        logic        vlds  [6] = '{1, 1, 1, 1, 0, 0};
        logic [12:0] exps  [6];
        exps[0] = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
        exps[1] = ex(1, 1, SEL_ADDSB, 0, 0, 0, 0);
        exps[2] = ex(1, 1, SEL_ADDSB, 1, 0, 0, 0);
        exps[3] = ex(1, 1, SEL_LOGIC, 0, 0, 0, 0);
        exps[4] = ex(1, 1, SEL_COM,   1, 0, 0, 0);
        exps[5] = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.op_valid_i = vlds[k];
            bus.op_code_i  = codes[k];
            #1;
            checks++;
            if (obs !== exps[k]) begin
                errors++;
                $display("FAIL b2b_c%0d obs=%b exp=%b", k, obs, exps[k]);
            end
            tick();
        end
    endtask

    task automatic test_mul_latency();
        alu_op_e     codes [8] = '{OP_MULH, OP_ADD, OP_ADD, OP_MUL, OP_ADD, OP_ADD, OP_ADD, OP_ADD};
        logic        vlds  [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        logic [12:0] exps  [8];
        exps[0] = ex(1, 0, SEL_NONE,  0, 1, 0, 0);
        exps[1] = ex(0, 0, SEL_MULHI, 0, 0, 0, 0);
        exps[2] = ex(0, 0, SEL_MULHI, 0, 0, 0, 0);
        exps[3] = ex(1, 1, SEL_MULHI, 0, 1, 0, 0);
        exps[4] = ex(0, 0, SEL_MULLO, 0, 0, 0, 0);
        exps[5] = ex(0, 0, SEL_MULLO, 0, 0, 0, 0);
        exps[6] = ex(1, 1, SEL_MULLO, 0, 0, 0, 0);
        exps[7] = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.op_valid_i = vlds[k];
            bus.op_code_i  = codes[k];
            #1;
            checks++;
            if (obs !== exps[k]) begin
                errors++;
                $display("FAIL mul_lat_c%0d obs=%b exp=%b", k, obs, exps[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] e;
        for (int k = 0; k < 8; k++) begin
            bus.op_valid_i     = (k < 6);
            bus.op_code_i      = (k == 0) ? OP_SLL : OP_ADD;
            bus.result_ready_i = (k >= 6);
            if (k == 0)      e = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
            else if (k < 6)  e = ex(0, 1, SEL_SHIFT, 0, 0, 0, 0);
            else if (k == 6) e = ex(1, 1, SEL_SHIFT, 0, 0, 0, 0);
            else             e = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
            #1;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL backpressure_c%0d obs=%b exp=%b", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_mac_commit();
        logic        rrdys [7] = '{0, 0, 0, 0, 0, 1, 1};
        logic [12:0] exps  [7];
        int          commits = 0;
        exps[0] = ex(1, 0, SEL_NONE, 0, 1, 0, 0);
        exps[1] = ex(0, 0, SEL_MAC,  0, 0, 0, 0);
        exps[2] = ex(0, 0, SEL_MAC,  0, 0, 0, 0);
        exps[3] = ex(0, 1, SEL_MAC,  0, 0, 0, 0);
        exps[4] = ex(0, 1, SEL_MAC,  0, 0, 0, 0);
        exps[5] = ex(1, 1, SEL_MAC,  0, 0, 1, 0);
        exps[6] = ex(1, 0, SEL_NONE, 0, 0, 0, 0);
        bus.op_code_i = OP_MAC;
        for (int k = 0; k < 7; k++) begin
            bus.op_valid_i     = (k == 0);
            bus.result_ready_i = rrdys[k];
            #1;
            if (bus.mac_commit_o === 1'b1) commits++;
            checks++;
            if (obs !== exps[k]) begin
                errors++;
                $display("FAIL mac_c%0d obs=%b exp=%b", k, obs, exps[k]);
            end
            tick();
        end
        checks++;
        if (commits !== 1) begin errors++; $display("FAIL mac_commit_count got=%0d exp=1", commits); end
    endtask

    task automatic test_illegal();
        alu_op_e     codes [4];
        logic [12:0] exps  [4];
        codes[0] = alu_op_e'(4'd14);
        codes[1] = OP_AND;
        codes[2] = OP_AND;
        codes[3] = OP_AND;
        exps[0]  = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
        exps[1]  = ex(1, 0, SEL_NONE,  0, 0, 0, 1);
        exps[2]  = ex(1, 1, SEL_LOGIC, 0, 0, 0, 0);
        exps[3]  = ex(1, 0, SEL_NONE,  0, 0, 0, 0);
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.op_valid_i = (k < 2);
            bus.op_code_i  = codes[k];
            #1;
            checks++;
            if (obs !== exps[k]) begin
                errors++;
                $display("FAIL illegal_c%0d obs=%b exp=%b", k, obs, exps[k]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul_latency();
        test_backpressure();
        test_mac_commit();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
